// File: rtl/soc_miner_mem_responder.sv
// ---------------------------------------------------------------------------
// soc_miner_mem_responder
//   AXI3 burst slave used as on-chip scratch memory / simulation target for
//   the soc_miner m_memory master port. Independent write and read engines,
//   each with a single outstanding burst, share a simple dual-port RAM with
//   byte enables. Every burst is treated as full-width INCR.
//
// Ports
//   Clk, Rst                 clock (rising edge), synchronous active-high reset
//   s_mem_aw*                write address channel (awvalid/awready/awaddr/awlen/awid)
//   s_mem_w*                 write data channel (wvalid/wready/wdata/wstrb/wlast)
//   s_mem_b*                 write response channel (bvalid/bready/bresp/bid)
//   s_mem_ar*                read address channel (arvalid/arready/araddr/arlen/arid)
//   s_mem_r*                 read data channel (rvalid/rready/rdata/rresp/rlast/rid)
//
// Configuration macro
//   SOC_MEM_RESP_BOUNDS_CHECK_EN
//     defined   : beats addressing past the end of the RAM are dropped (write)
//                 or return zero (read) and are answered with SLVERR.
//     undefined : word index simply wraps modulo the RAM depth.
// ---------------------------------------------------------------------------
module soc_miner_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 6,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    Clk,
  input  logic                    Rst,
  // write address
  input  logic                    s_mem_awvalid,
  output logic                    s_mem_awready,
  input  logic [ADDR_WIDTH-1:0]   s_mem_awaddr,
  input  logic [LEN_WIDTH-1:0]    s_mem_awlen,
  input  logic [ID_WIDTH-1:0]     s_mem_awid,
  // write data
  input  logic                    s_mem_wvalid,
  output logic                    s_mem_wready,
  input  logic [DATA_WIDTH-1:0]   s_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_mem_wstrb,
  input  logic                    s_mem_wlast,
  // write response
  output logic                    s_mem_bvalid,
  input  logic                    s_mem_bready,
  output logic [1:0]              s_mem_bresp,
  output logic [ID_WIDTH-1:0]     s_mem_bid,
  // read address
  input  logic                    s_mem_arvalid,
  output logic                    s_mem_arready,
  input  logic [ADDR_WIDTH-1:0]   s_mem_araddr,
  input  logic [LEN_WIDTH-1:0]    s_mem_arlen,
  input  logic [ID_WIDTH-1:0]     s_mem_arid,
  // read data
  output logic                    s_mem_rvalid,
  input  logic                    s_mem_rready,
  output logic [DATA_WIDTH-1:0]   s_mem_rdata,
  output logic [1:0]              s_mem_rresp,
  output logic                    s_mem_rlast,
  output logic [ID_WIDTH-1:0]     s_mem_rid
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int WA_W   = ADDR_WIDTH - OFFS;   // full word-address width
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write engine state ----------------
  wstate_t               wstate_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [WA_W-1:0]       waddr_q;    // full word address, low bits index the RAM
  logic [LEN_WIDTH-1:0]  wlen_q;
  logic [LEN_WIDTH-1:0]  wcnt_q;
  logic [ID_WIDTH-1:0]   wid_q;
  logic                  werr_q;     // sticky burst error

  // ---------------- read engine state ----------------
  rstate_t               rstate_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [WA_W-1:0]       raddr_q;
  logic [LEN_WIDTH-1:0]  rlen_q;
  logic [LEN_WIDTH-1:0]  rcnt_q;
  logic [ID_WIDTH-1:0]   rlid_q;

  // ---------------- combinational helpers ----------------
  logic                  w_hs;
  logic                  w_final;
  logic                  w_oob;
  logic                  r_oob;
  logic                  werr_d;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] widx;
  logic [DEPTH_LOG2-1:0] ridx;

  assign widx    = waddr_q[DEPTH_LOG2-1:0];
  assign ridx    = raddr_q[DEPTH_LOG2-1:0];
  assign w_hs    = wready_q && s_mem_wvalid;
  assign w_final = (wcnt_q == wlen_q);

`ifdef SOC_MEM_RESP_BOUNDS_CHECK_EN
  // Any set bit above the RAM index means the byte address is past the end.
  assign w_oob = |waddr_q[WA_W-1:DEPTH_LOG2];
  assign r_oob = |raddr_q[WA_W-1:DEPTH_LOG2];
  logic unused_addr;
  assign unused_addr = ^{s_mem_awaddr[OFFS-1:0], s_mem_araddr[OFFS-1:0]};
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{s_mem_awaddr[OFFS-1:0], s_mem_araddr[OFFS-1:0],
                         waddr_q[WA_W-1:DEPTH_LOG2], raddr_q[WA_W-1:DEPTH_LOG2]};
`endif

  // A beat is in error if wlast disagrees with the beat count, or it is out of range.
  assign werr_d = werr_q | (s_mem_wlast != w_final) | w_oob;
  // Gated by Rst so a burst interrupted by reset writes nothing on the reset edge.
  assign ram_we = w_hs && !w_oob && !Rst;

  // ---------------- write FSM ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_mem_awvalid && awready_q) begin
            waddr_q   <= s_mem_awaddr[ADDR_WIDTH-1:OFFS];
            wlen_q    <= s_mem_awlen;
            wid_q     <= s_mem_awid;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr_q <= waddr_q + WA_W'(1);
            wcnt_q  <= wcnt_q + LEN_WIDTH'(1);
            werr_q  <= werr_d;
            // The beat count, not wlast, closes the burst.
            if (w_final) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= wid_q;
              bresp_q  <= werr_d ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_mem_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rcnt_q    <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_mem_arvalid && arready_q) begin
            raddr_q   <= s_mem_araddr[ADDR_WIDTH-1:OFFS];
            rlen_q    <= s_mem_arlen;
            rlid_q    <= s_mem_arid;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rstate_q  <= R_FETCH;
          end
        end
        R_FETCH: begin
          // RAM output register is loaded on this same edge.
          rvalid_q <= 1'b1;
          rlast_q  <= (rcnt_q == rlen_q);
          rid_q    <= rlid_q;
          rresp_q  <= r_oob ? RESP_SLVERR : RESP_OKAY;
          rstate_q <= R_DATA;
        end
        R_DATA: begin
          if (s_mem_rready && rvalid_q) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              raddr_q  <= raddr_q + WA_W'(1);
              rcnt_q   <= rcnt_q + LEN_WIDTH'(1);
              rstate_q <= R_FETCH;
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- RAM ----------------
  // Write port: byte-enabled. Nonblocking write plus registered read on the
  // same edge gives read-first behaviour for a same-word collision.
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_mem_wstrb[b]) mem[widx][b*8 +: 8] <= s_mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read port: loaded only in R_FETCH so rdata holds while the master stalls.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rdata_q <= '0;
    end else if (rstate_q == R_FETCH) begin
      rdata_q <= r_oob ? '0 : mem[ridx];
    end
  end

  assign s_mem_awready = awready_q;
  assign s_mem_wready  = wready_q;
  assign s_mem_bvalid  = bvalid_q;
  assign s_mem_bresp   = bresp_q;
  assign s_mem_bid     = bid_q;
  assign s_mem_arready = arready_q;
  assign s_mem_rvalid  = rvalid_q;
  assign s_mem_rdata   = rdata_q;
  assign s_mem_rresp   = rresp_q;
  assign s_mem_rlast   = rlast_q;
  assign s_mem_rid     = rid_q;

endmodule

// File: tb/tb_soc_miner_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_soc_miner_mem_responder
//   Directed self-checking bench for soc_miner_mem_responder: reset state,
//   single-beat write/read, 16-beat burst with read back-pressure, byte
//   strobes, wlast mismatch, out-of-range address and reset mid-burst.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_soc_miner_mem_responder;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [5:0]  awid;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [5:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [5:0]  arid;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [5:0]  rid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [5:0]  rd_id   [16];
  int          rd_unstable;
  logic [1:0]  b_resp;
  logic [5:0]  b_id;

  always #5 Clk = ~Clk;

  soc_miner_mem_responder dut (
    .Clk(Clk), .Rst(Rst),
    .s_mem_awvalid(awvalid), .s_mem_awready(awready), .s_mem_awaddr(awaddr),
    .s_mem_awlen(awlen), .s_mem_awid(awid),
    .s_mem_wvalid(wvalid), .s_mem_wready(wready), .s_mem_wdata(wdata),
    .s_mem_wstrb(wstrb), .s_mem_wlast(wlast),
    .s_mem_bvalid(bvalid), .s_mem_bready(bready), .s_mem_bresp(bresp), .s_mem_bid(bid),
    .s_mem_arvalid(arvalid), .s_mem_arready(arready), .s_mem_araddr(araddr),
    .s_mem_arlen(arlen), .s_mem_arid(arid),
    .s_mem_rvalid(rvalid), .s_mem_rready(rready), .s_mem_rdata(rdata),
    .s_mem_rresp(rresp), .s_mem_rlast(rlast), .s_mem_rid(rid)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drives one write burst; bad_last < 0 gives a correct wlast, otherwise wlast
  // is asserted only on beat bad_last.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [5:0] id,
                           input int bad_last);
    int cyc;
    awvalid = 1'b1; awaddr = addr; awlen = 4'(len); awid = id;
    cyc = 0;
    while (!awready && cyc < 100) begin tick(); cyc++; end
    if (!awready) begin
      n_checks++; n_fail++;
      $display("FAIL aw_timeout awready=%0b expected 1", awready);
      awvalid = 1'b0;
      return;
    end
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wr_data[i]; wstrb = wr_strb[i];
      wlast  = (bad_last >= 0) ? (i == bad_last) : (i == len);
      cyc = 0;
      while (!wready && cyc < 100) begin tick(); cyc++; end
      if (!wready) begin
        n_checks++; n_fail++;
        $display("FAIL w_timeout beat %0d wready=%0b expected 1", i, wready);
        wvalid = 1'b0;
        return;
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < 100) begin tick(); cyc++; end
    if (!bvalid) begin
      n_checks++; n_fail++;
      $display("FAIL b_timeout bvalid=%0b expected 1", bvalid);
    end
    b_resp = bresp; b_id = bid;
    tick();
    bready = 1'b0;
  endtask

  // Reads one burst into rd_*; with stall set every beat is held off one cycle
  // before it is accepted, and rd_unstable counts outputs that moved meanwhile.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [5:0] id,
                          input bit stall);
    int cyc, beat;
    logic prev_stall, prev_last;
    logic [63:0] prev_data;
    logic [5:0] prev_id;
    arvalid = 1'b1; araddr = addr; arlen = 4'(len); arid = id;
    cyc = 0;
    while (!arready && cyc < 100) begin tick(); cyc++; end
    if (!arready) begin
      n_checks++; n_fail++;
      $display("FAIL ar_timeout arready=%0b expected 1", arready);
      arvalid = 1'b0;
      return;
    end
    tick();
    arvalid = 1'b0;
    beat = 0; rd_unstable = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_id = '0;
    for (cyc = 0; cyc < 300 && beat <= len; cyc++) begin
      rready = stall ? (rvalid && prev_stall) : 1'b1;
      if (rvalid && prev_stall &&
          (rdata !== prev_data || rlast !== prev_last || rid !== prev_id)) rd_unstable++;
      if (rvalid && rready) begin
        rd_data[beat] = rdata; rd_resp[beat] = rresp;
        rd_last[beat] = rlast; rd_id[beat] = rid;
        beat++;
      end
      prev_stall = rvalid && !rready;
      prev_data = rdata; prev_last = rlast; prev_id = rid;
      tick();
    end
    rready = 1'b0;
    if (beat <= len) begin
      n_checks++; n_fail++;
      $display("FAIL r_timeout beats got %0d expected %0d", beat, len + 1);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl {aw,w,b,ar,r,rlast}=%b expected 000000",
               {awready, wready, bvalid, arready, rvalid, rlast});
    end
    n_checks++;
    if (rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h expected 0", rdata); end
    n_checks++;
    if ({bresp, rresp, bid, rid} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_resp_id got %h expected 0", {bresp, rresp, bid, rid});
    end
    Rst = 1'b0;
    tick();
    n_checks++;
    if (awready !== 1'b1) begin n_fail++; $display("FAIL reset_awready got %b expected 1", awready); end
    n_checks++;
    if (arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready got %b expected 1", arready); end
  endtask

  task automatic test_single();
    wr_data[0] = 64'hDEADBEEF_CAFEF00D; wr_strb[0] = 8'hFF;
    axi_write(32'h10, 0, 6'd5, -1);
    n_checks++;
    if (b_resp !== 2'b00) begin n_fail++; $display("FAIL single_bresp got %b expected 00", b_resp); end
    n_checks++;
    if (b_id !== 6'd5) begin n_fail++; $display("FAIL single_bid got %0d expected 5", b_id); end
    axi_read(32'h10, 0, 6'd5, 1'b0);
    n_checks++;
    if (rd_data[0] !== 64'hDEADBEEF_CAFEF00D) begin
      n_fail++; $display("FAIL single_rdata got %h expected deadbeefcafef00d", rd_data[0]);
    end
    n_checks++;
    if ({rd_id[0], rd_last[0], rd_resp[0]} !== {6'd5, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL single_rmeta rid=%0d rlast=%b rresp=%b expected 5 1 00",
               rd_id[0], rd_last[0], rd_resp[0]);
    end
  endtask

  task automatic test_burst_stall();
    for (int i = 0; i < 16; i++) begin wr_data[i] = 64'(i); wr_strb[i] = 8'hFF; end
    axi_write(32'h100, 15, 6'd9, -1);
    n_checks++;
    if (b_resp !== 2'b00 || b_id !== 6'd9) begin
      n_fail++; $display("FAIL burst_b bresp=%b bid=%0d expected 00 9", b_resp, b_id);
    end
    axi_read(32'h100, 15, 6'd10, 1'b1);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'(i) || rd_last[i] !== (i == 15) || rd_id[i] !== 6'd10) begin
        n_fail++;
        $display("FAIL burst_beat%0d data=%h rlast=%b rid=%0d expected %h %b 10",
                 i, rd_data[i], rd_last[i], rd_id[i], 64'(i), (i == 15));
      end
    end
    n_checks++;
    if (rd_unstable !== 0) begin
      n_fail++; $display("FAIL burst_stable changes=%0d expected 0", rd_unstable);
    end
  endtask

  task automatic test_strobe();
    wr_data[0] = 64'hFFFFFFFF_FFFFFFFF; wr_strb[0] = 8'hFF;
    axi_write(32'h200, 0, 6'd1, -1);
    wr_data[0] = 64'h0; wr_strb[0] = 8'h0F;
    axi_write(32'h200, 0, 6'd2, -1);
    axi_read(32'h200, 0, 6'd3, 1'b0);
    n_checks++;
    if (rd_data[0] !== 64'hFFFFFFFF_00000000) begin
      n_fail++; $display("FAIL strobe_rdata got %h expected ffffffff00000000", rd_data[0]);
    end
  endtask

  task automatic test_wlast_err();
    for (int i = 0; i < 4; i++) begin wr_data[i] = 64'hA0 + 64'(i); wr_strb[i] = 8'hFF; end
    axi_write(32'h300, 3, 6'd7, 2);
    n_checks++;
    if (b_resp !== 2'b10 || b_id !== 6'd7) begin
      n_fail++; $display("FAIL wlast_bresp bresp=%b bid=%0d expected 10 7", b_resp, b_id);
    end
    axi_read(32'h300, 3, 6'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'hA0 + 64'(i)) begin
        n_fail++; $display("FAIL wlast_data%0d got %h expected %h", i, rd_data[i], 64'hA0 + 64'(i));
      end
    end
  endtask

  task automatic test_bounds();
    wr_data[0] = 64'h11111111_11111111; wr_strb[0] = 8'hFF;
    axi_write(32'h0, 0, 6'd4, -1);
    wr_data[0] = 64'h55555555_55555555;
    axi_write(32'h2000, 0, 6'd4, -1);
`ifdef SOC_MEM_RESP_BOUNDS_CHECK_EN
    n_checks++;
    if (b_resp !== 2'b10) begin n_fail++; $display("FAIL bounds_bresp got %b expected 10", b_resp); end
    axi_read(32'h2000, 0, 6'd4, 1'b0);
    n_checks++;
    if (rd_data[0] !== 64'h0 || rd_resp[0] !== 2'b10) begin
      n_fail++; $display("FAIL bounds_read data=%h rresp=%b expected 0 10", rd_data[0], rd_resp[0]);
    end
    axi_read(32'h0, 0, 6'd4, 1'b0);
    n_checks++;
    if (rd_data[0] !== 64'h11111111_11111111) begin
      n_fail++; $display("FAIL bounds_word0 got %h expected 1111111111111111", rd_data[0]);
    end
`else
    n_checks++;
    if (b_resp !== 2'b00) begin n_fail++; $display("FAIL alias_bresp got %b expected 00", b_resp); end
    axi_read(32'h2000, 0, 6'd4, 1'b0);
    n_checks++;
    if (rd_data[0] !== 64'h55555555_55555555 || rd_resp[0] !== 2'b00) begin
      n_fail++; $display("FAIL alias_read data=%h rresp=%b expected 5555555555555555 00", rd_data[0], rd_resp[0]);
    end
    axi_read(32'h0, 0, 6'd4, 1'b0);
    n_checks++;
    if (rd_data[0] !== 64'h55555555_55555555) begin
      n_fail++; $display("FAIL alias_word0 got %h expected 5555555555555555", rd_data[0]);
    end
`endif
  endtask

  task automatic test_reset_midburst();
    int beat, cyc;
    bit hit;
    for (int i = 0; i < 8; i++) begin wr_data[i] = 64'hC0 + 64'(i); wr_strb[i] = 8'hFF; end
    axi_write(32'h400, 7, 6'd12, -1);
    arvalid = 1'b1; araddr = 32'h400; arlen = 4'd7; arid = 6'd12;
    tick();                       // arready already high in idle
    arvalid = 1'b0;
    beat = 0; hit = 1'b0;
    for (cyc = 0; cyc < 100 && !hit; cyc++) begin
      if (rvalid && beat == 3) begin
        hit = 1'b1;
      end else begin
        rready = 1'b1;
        if (rvalid) beat++;
        tick();
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL rst_mid_reach beats=%0d expected 3", beat);
    end
    rready = 1'b0; Rst = 1'b1;
    tick();
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid_rvalid rvalid=%b rdata=%h expected 0 0", rvalid, rdata);
    end
    Rst = 1'b0;
    tick();
    n_checks++;
    if (arready !== 1'b1 || awready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready arready=%b awready=%b expected 1 1", arready, awready);
    end
    axi_read(32'h400, 7, 6'd13, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'hC0 + 64'(i)) begin
        n_fail++; $display("FAIL rst_mid_data%0d got %h expected %h", i, rd_data[i], 64'hC0 + 64'(i));
      end
    end
    axi_read(32'h10, 0, 6'd5, 1'b0);
    n_checks++;
    if (rd_data[0] !== 64'hDEADBEEF_CAFEF00D) begin
      n_fail++; $display("FAIL rst_mid_old got %h expected deadbeefcafef00d", rd_data[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    awvalid = 1'b0; awaddr = '0; awlen = '0; awid = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arlen = '0; arid = '0;
    rready = 1'b0;
    test_reset();
    test_single();
    test_burst_stall();
    test_strobe();
    test_wlast_err();
    test_bounds();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
